// File: rtl/pc_fetch_unit.sv
// Instruction fetch: program counter plus the IF/ID pipeline register, with stall and branch redirect.
// Latency: a redirect target is on pc one cycle after branch_taken; its instruction reaches IF/ID at the next advance.
// Backpressure: stall holds pc, IF/ID and fetch_count; branch_taken overrides stall and inserts a bubble.
module pc_fetch_unit #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h00000013,
    parameter int               CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [31:0]      instr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] if_id_pc_nxt;
    logic [31:0]      if_id_instr_nxt;
    logic             if_id_valid_nxt;
    logic             misalign_err_nxt;
    logic [CNT_W-1:0] fetch_count_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BUBBLE;
            pc           <= RESET_PC;
            if_id_pc     <= '0;
            if_id_instr  <= NOP_INSTR;
            if_id_valid  <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            if_id_pc     <= if_id_pc_nxt;
            if_id_instr  <= if_id_instr_nxt;
            if_id_valid  <= if_id_valid_nxt;
            misalign_err <= misalign_err_nxt;
            fetch_count  <= fetch_count_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        pc_nxt           = pc;
        if_id_pc_nxt     = if_id_pc;
        if_id_instr_nxt  = if_id_instr;
        if_id_valid_nxt  = if_id_valid;
        misalign_err_nxt = misalign_err;
        fetch_count_nxt  = fetch_count;

        if (branch_taken) begin
            state_nxt       = BUBBLE;
            pc_nxt          = {branch_target[WIDTH-1:2], 2'b00};
            if_id_pc_nxt    = '0;
            if_id_instr_nxt = NOP_INSTR;
            if_id_valid_nxt = 1'b0;
            if (branch_target[1:0] != 2'b00)
                misalign_err_nxt = 1'b1;
        end else if (stall) begin
            state_nxt = HOLD;
            // A stall straight after a redirect keeps the bubble in ID.
            if (state == BUBBLE) begin
                state_nxt       = BUBBLE;
                if_id_pc_nxt    = '0;
                if_id_instr_nxt = NOP_INSTR;
                if_id_valid_nxt = 1'b0;
            end
        end else begin
            state_nxt       = RUN;
            pc_nxt          = pc_plus4;
            if_id_pc_nxt    = pc;
            if_id_instr_nxt = instr;
            if_id_valid_nxt = 1'b1;
            if (fetch_count != {CNT_W{1'b1}})
                fetch_count_nxt = fetch_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: advance, stall, redirect, misalignment, wrap, saturation and reset cases.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken;
    logic [63:0] branch_target, pc_plus4, pc, if_id_pc;
    logic [31:0] instr, if_id_instr;
    logic        if_id_valid, misalign_err;
    logic [31:0] fetch_count;

    logic        s_reset;
    logic [63:0] s_pc, s_pc_plus4, s_if_id_pc;
    logic [31:0] s_if_id_instr;
    logic        s_if_id_valid, s_misalign_err;
    logic [2:0]  s_fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    assign pc_plus4   = pc + 64'd4;
    assign instr      = imem(pc);
    assign s_pc_plus4 = s_pc + 64'd4;

    pc_fetch_unit #(.WIDTH(64), .RESET_PC(64'h1000), .NOP_INSTR(32'h00000013), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .pc_plus4(pc_plus4), .instr(instr),
        .pc(pc), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    pc_fetch_unit #(.WIDTH(64), .RESET_PC(64'h0), .NOP_INSTR(32'h00000013), .CNT_W(3)) u_sat (
        .clk(clk), .reset(s_reset), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(64'h0), .pc_plus4(s_pc_plus4), .instr(32'h0),
        .pc(s_pc), .if_id_pc(s_if_id_pc), .if_id_instr(s_if_id_instr), .if_id_valid(s_if_id_valid),
        .misalign_err(s_misalign_err), .fetch_count(s_fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic [63:0] t);
        reset = r; stall = s; branch_taken = b; branch_target = t;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 64'h0);
        step(); step();
        n_checks++; if (pc !== 64'h1000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 64'h1000); end
        n_checks++; if (if_id_pc !== 64'h0) begin n_fail++; $display("FAIL reset_if_id_pc: got %h want 0", if_id_pc); end
        n_checks++; if (if_id_instr !== 32'h13) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", if_id_instr); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", misalign_err); end
        n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    endtask

    task automatic test_advance();
        drive(0, 0, 0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            logic [63:0] prev;
            prev = 64'h1000 + 64'(4 * i);
            step();
            n_checks++; if (pc !== prev + 64'd4) begin n_fail++; $display("FAIL adv_pc[%0d]: got %h want %h", i, pc, prev + 64'd4); end
            n_checks++; if (if_id_pc !== prev) begin n_fail++; $display("FAIL adv_if_id_pc[%0d]: got %h want %h", i, if_id_pc, prev); end
            n_checks++; if (if_id_instr !== imem(prev)) begin n_fail++; $display("FAIL adv_instr[%0d]: got %h want %h", i, if_id_instr, imem(prev)); end
            n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL adv_valid[%0d]: got %b want 1", i, if_id_valid); end
            n_checks++; if (fetch_count !== 32'(i + 1)) begin n_fail++; $display("FAIL adv_count[%0d]: got %0d want %0d", i, fetch_count, i + 1); end
        end
    endtask

    task automatic test_stall();
        drive(1, 0, 0, 64'h0); step();
        drive(0, 0, 0, 64'h0); step(); step();
        n_checks++; if (pc !== 64'h1008) begin n_fail++; $display("FAIL stall_setup_pc: got %h want 1008", pc); end
        drive(0, 1, 0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (pc !== 64'h1008) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 1008", i, pc); end
            n_checks++; if (if_id_pc !== 64'h1004 || if_id_valid !== 1'b1 || if_id_instr !== imem(64'h1004))
                begin n_fail++; $display("FAIL stall_if_id[%0d]: got %h/%b/%h want 1004/1/%h", i, if_id_pc, if_id_valid, if_id_instr, imem(64'h1004)); end
            n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d want 2", i, fetch_count); end
        end
        drive(0, 0, 0, 64'h0); step();
        n_checks++; if (pc !== 64'h100C) begin n_fail++; $display("FAIL stall_resume_pc: got %h want 100c", pc); end
        n_checks++; if (if_id_pc !== 64'h1008) begin n_fail++; $display("FAIL stall_resume_if_id_pc: got %h want 1008", if_id_pc); end
        n_checks++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL stall_resume_count: got %0d want 3", fetch_count); end
    endtask

    task automatic test_redirect_stall();
        drive(0, 1, 1, 64'h2000); step();
        n_checks++; if (pc !== 64'h2000) begin n_fail++; $display("FAIL redir_pc: got %h want 2000", pc); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b want 0", if_id_valid); end
        n_checks++; if (if_id_instr !== 32'h13) begin n_fail++; $display("FAIL redir_instr: got %h want 00000013", if_id_instr); end
        n_checks++; if (if_id_pc !== 64'h0) begin n_fail++; $display("FAIL redir_if_id_pc: got %h want 0", if_id_pc); end
        n_checks++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL redir_count: got %0d want 3", fetch_count); end
        drive(0, 1, 0, 64'h0); step();
        n_checks++; if (pc !== 64'h2000 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stall_hold: got %h/%b want 2000/0", pc, if_id_valid); end
        drive(0, 0, 0, 64'h0); step();
        n_checks++; if (if_id_pc !== 64'h2000 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL redir_arrive: got %h/%b want 2000/1", if_id_pc, if_id_valid); end
        n_checks++; if (if_id_instr !== imem(64'h2000)) begin n_fail++; $display("FAIL redir_arrive_instr: got %h want %h", if_id_instr, imem(64'h2000)); end
        n_checks++; if (fetch_count !== 32'd4) begin n_fail++; $display("FAIL redir_arrive_count: got %0d want 4", fetch_count); end
    endtask

    task automatic test_misalign();
        drive(0, 0, 1, 64'h2002); step();
        n_checks++; if (pc !== 64'h2000) begin n_fail++; $display("FAIL mis_pc: got %h want 2000", pc); end
        n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b want 1", misalign_err); end
        drive(0, 0, 0, 64'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_sticky[%0d]: got %b want 1", i, misalign_err); end
        end
        drive(1, 0, 0, 64'h0); step();
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", misalign_err); end
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 1, 64'h3000); step();
        n_checks++; if (pc !== 64'h3000 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got %h/%b want 3000/0", pc, if_id_valid); end
        drive(0, 0, 1, 64'h4000); step();
        n_checks++; if (pc !== 64'h4000 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got %h/%b want 4000/0", pc, if_id_valid); end
        drive(0, 0, 0, 64'h0); step();
        n_checks++; if (if_id_pc !== 64'h4000 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_arrive: got %h/%b want 4000/1", if_id_pc, if_id_valid); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", misalign_err); end
    endtask

    task automatic test_wrap();
        drive(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC); step();
        n_checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h want fffffffffffffffc", pc); end
        drive(0, 0, 0, 64'h0); step();
        n_checks++; if (pc !== 64'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", pc); end
        n_checks++; if (if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_if_id_pc: got %h want fffffffffffffffc", if_id_pc); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b want 0", misalign_err); end
    endtask

    task automatic test_saturate();
        s_reset = 1'b1; step();
        n_checks++; if (s_fetch_count !== 3'd0) begin n_fail++; $display("FAIL sat_reset: got %0d want 0", s_fetch_count); end
        s_reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            logic [2:0] exp;
            exp = (i > 7) ? 3'd7 : 3'(i);
            step();
            n_checks++; if (s_fetch_count !== exp) begin n_fail++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, s_fetch_count, exp); end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 0, 64'h0); step(); step();
        drive(1, 1, 0, 64'h0); step();
        n_checks++; if (pc !== 64'h1000 || if_id_valid !== 1'b0 || if_id_pc !== 64'h0 || if_id_instr !== 32'h13 || fetch_count !== 32'd0)
            begin n_fail++; $display("FAIL rst_stall: got %h/%b/%h/%h/%0d want 1000/0/0/13/0", pc, if_id_valid, if_id_pc, if_id_instr, fetch_count); end
        drive(0, 0, 0, 64'h0); step();
        drive(1, 0, 1, 64'h5001); step();
        n_checks++; if (pc !== 64'h1000 || if_id_valid !== 1'b0 || if_id_pc !== 64'h0 || misalign_err !== 1'b0 || fetch_count !== 32'd0)
            begin n_fail++; $display("FAIL rst_redir: got %h/%b/%h/%b/%0d want 1000/0/0/0/0", pc, if_id_valid, if_id_pc, misalign_err, fetch_count); end
        drive(0, 0, 0, 64'h0); step();
        n_checks++; if (if_id_pc !== 64'h1000 || if_id_valid !== 1'b1 || pc !== 64'h1004)
            begin n_fail++; $display("FAIL rst_first: got %h/%b/%h want 1000/1/1004", if_id_pc, if_id_valid, pc); end
    endtask

    initial begin
        drive(1, 0, 0, 64'h0);
        s_reset = 1'b1;
        test_reset();
        test_advance();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_back_to_back();
        test_wrap();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
